// File: rtl/partial_sum_gatherer.sv
// Walks a MAX_ROW x MAX_COL frame, reads the four fp16 partial sums of each pixel
// (one per filter-group plane) and presents them packed, one enable_conv per pixel.
module partial_sum_gatherer #(
  parameter int          MAX_ROW   = 5,
  parameter int          MAX_COL   = 5,
  parameter int          ISSUE_GAP = 2,
  parameter logic [17:0] BASE_ADDR = 18'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        Input_BRAM_en,
  output logic [17:0] Input_read_addr,
  input  logic [15:0] Input_read_data,
  output logic [63:0] conv_concat,
  output logic        enable_conv,
  output logic        busy,
  output logic        done
);

  localparam int ROW_W = (MAX_ROW > 1) ? $clog2(MAX_ROW) : 1;
  localparam int COL_W = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;
  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  localparam logic [17:0]      PLANE    = 18'(MAX_ROW * MAX_COL);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAX_ROW - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(MAX_COL - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(ISSUE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_ISSUE,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_reg;
  logic [ROW_W-1:0] row_reg;
  logic [COL_W-1:0] col_reg;
  logic [1:0]       lane_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [17:0]      pix_addr_reg;
  logic [17:0]      read_addr_reg;
  logic             bram_en_reg;
  logic             enable_conv_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             rd_pending_reg;
  logic [1:0]       pend_lane_reg;

  logic last_pix;
  logic col_wrap;
  logic pixel_end;

  assign col_wrap  = (col_reg == LAST_COL);
  assign last_pix  = (row_reg == LAST_ROW) && col_wrap;
  // A pixel slot ends at ISSUE when there is no gap, otherwise on the last GAP cycle.
  assign pixel_end = ((state_reg == S_ISSUE) && (ISSUE_GAP == 0)) ||
                     ((state_reg == S_GAP) && (gap_cnt_reg == LAST_GAP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      row_reg         <= '0;
      col_reg         <= '0;
      lane_reg        <= '0;
      gap_cnt_reg     <= '0;
      pix_addr_reg    <= '0;
      read_addr_reg   <= '0;
      bram_en_reg     <= 1'b0;
      enable_conv_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg     <= S_READ;
            busy_reg      <= 1'b1;
            bram_en_reg   <= 1'b1;
            read_addr_reg <= BASE_ADDR;
            pix_addr_reg  <= BASE_ADDR;
            row_reg       <= '0;
            col_reg       <= '0;
            lane_reg      <= '0;
          end
        end
        S_READ: begin
          if (lane_reg == 2'd3) begin
            state_reg   <= S_WAIT;
            bram_en_reg <= 1'b0;
          end else begin
            lane_reg      <= lane_reg + 2'd1;
            read_addr_reg <= read_addr_reg + PLANE;
          end
        end
        S_WAIT: begin
          state_reg       <= S_ISSUE;
          enable_conv_reg <= 1'b1;
        end
        S_ISSUE: begin
          enable_conv_reg <= 1'b0;
          gap_cnt_reg     <= '0;
          if (ISSUE_GAP != 0) state_reg <= S_GAP;
        end
        S_GAP: begin
          gap_cnt_reg <= gap_cnt_reg + 1'b1;
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= S_IDLE;
      endcase

      // Overrides the per-state transition above at the end of each pixel slot.
      if (pixel_end) begin
        if (last_pix) begin
          state_reg <= S_DONE;
          done_reg  <= 1'b1;
        end else begin
          state_reg     <= S_READ;
          lane_reg      <= '0;
          bram_en_reg   <= 1'b1;
          pix_addr_reg  <= pix_addr_reg + 18'd1;
          read_addr_reg <= pix_addr_reg + 18'd1;
          if (col_wrap) begin
            col_reg <= '0;
            row_reg <= row_reg + 1'b1;
          end else begin
            col_reg <= col_reg + 1'b1;
          end
        end
      end
    end
  end

  // Read data arrives one cycle after the enable; remember which lane it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending_reg <= 1'b0;
      pend_lane_reg  <= '0;
    end else begin
      rd_pending_reg <= bram_en_reg;
      pend_lane_reg  <= lane_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [15:0] lane_data_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_data_reg <= '0;
        end else if (rd_pending_reg && (pend_lane_reg == 2'(gi))) begin
          lane_data_reg <= Input_read_data;
        end
      end
      assign conv_concat[16*gi +: 16] = lane_data_reg;
    end
  endgenerate

  assign Input_BRAM_en   = bram_en_reg;
  assign Input_read_addr = read_addr_reg;
  assign enable_conv     = enable_conv_reg;
  assign busy            = busy_reg;
  assign done            = done_reg;

endmodule

// File: tb/tb_partial_sum_gatherer.sv
// Bench for partial_sum_gatherer: a default-parameter instance and a small
// wrap-parameter instance, each fed by a synchronous BRAM model.
module tb_partial_sum_gatherer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        bram_en;
  logic [17:0] read_addr;
  logic [15:0] read_data = '0;
  logic [63:0] conv_concat;
  logic        enable_conv, busy, done;

  logic        start_w = 1'b0;
  logic        bram_en_w;
  logic [17:0] read_addr_w;
  logic [15:0] read_data_w = '0;
  logic [63:0] conv_concat_w;
  logic        enable_conv_w, busy_w, done_w;

  partial_sum_gatherer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .Input_BRAM_en(bram_en), .Input_read_addr(read_addr), .Input_read_data(read_data),
    .conv_concat(conv_concat), .enable_conv(enable_conv), .busy(busy), .done(done)
  );

  partial_sum_gatherer #(
    .MAX_ROW(2), .MAX_COL(3), .ISSUE_GAP(0), .BASE_ADDR(18'd100)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w),
    .Input_BRAM_en(bram_en_w), .Input_read_addr(read_addr_w), .Input_read_data(read_data_w),
    .conv_concat(conv_concat_w), .enable_conv(enable_conv_w), .busy(busy_w), .done(done_w)
  );

  logic [15:0] mem   [128];
  logic [15:0] mem_w [256];
  always @(posedge clk) if (bram_en)   read_data   <= mem[read_addr[6:0]];
  always @(posedge clk) if (bram_en_w) read_data_w <= mem_w[read_addr_w[7:0]];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] exp_q[$];
  logic [63:0] exp_w_q[$];
  logic [17:0] waddr_q[$];
  int prev_pulse = -1, frame_pulses = 0, done_cnt = 0;
  int prev_w = -1, pulses_w = 0;

  typedef struct packed {
    logic [3:0][15:0] plane;
    logic [63:0]      expect_concat;
  } vec_t;
  vec_t vecs[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Default instance: scoreboard pop, pulse spacing and done placement.
  always @(negedge clk) begin
    if (enable_conv) begin
      if (prev_pulse >= 0) check("pulse_spacing", 64'(cyc - prev_pulse), 64'd8);
      prev_pulse = cyc;
      frame_pulses++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got concat %0h, required no pulse", conv_concat);
      end else begin
        check("concat", conv_concat, exp_q.pop_front());
      end
    end
    if (done) begin
      done_cnt++;
      check("done_after_gap", 64'(cyc - prev_pulse), 64'd3);
    end
  end

  // Wrap instance.
  always @(negedge clk) begin
    if (bram_en_w) waddr_q.push_back(read_addr_w);
    if (enable_conv_w) begin
      if (prev_w >= 0) check("w_pulse_spacing", 64'(cyc - prev_w), 64'd6);
      prev_w = cyc;
      pulses_w++;
      if (exp_w_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL w_unexpected_pulse: got concat %0h, required no pulse", conv_concat_w);
      end else begin
        check("w_concat", conv_concat_w, exp_w_q.pop_front());
      end
    end
    if (done_w) check("w_done_after_issue", 64'(cyc - prev_w), 64'd1);
  end

  task automatic push_addr_frame();
    for (int p = 0; p < 25; p++)
      exp_q.push_back({16'(p + 75), 16'(p + 50), 16'(p + 25), 16'(p)});
  endtask

  task automatic new_frame();
    prev_pulse = -1;
    frame_pulses = 0;
    done_cnt = 0;
  endtask

  // Leaves the bench at #1 into c1 (start sampled at the edge ending c0).
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit pulse_on_done);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        seen = 1'b1;
        if (pulse_on_done) begin
          start = 1'b1;
          @(posedge clk); #1 start = 1'b0;
        end
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done in %0d cycles, required done", budget);
    end
  endtask

  initial begin
    vecs[0] = '{plane: {16'h4400, 16'h4200, 16'h4000, 16'h3C00}, expect_concat: 64'h4400_4200_4000_3C00};
    vecs[1] = '{plane: {16'h0001, 16'h8000, 16'h0000, 16'hFFFF}, expect_concat: 64'h0001_8000_0000_FFFF};
    vecs[2] = '{plane: {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}, expect_concat: 64'hDEF0_9ABC_5678_1234};
    for (int a = 0; a < 128; a++) mem[a] = 16'(a);
    for (int a = 0; a < 256; a++) mem_w[a] = 16'(a);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_bram_en", 64'(bram_en), 64'd0);
    check("rst_addr", 64'(read_addr), 64'd0);
    check("rst_concat", conv_concat, 64'd0);
    check("rst_outs", {61'd0, enable_conv, busy, done}, 64'd0);
    rst_n = 1'b1;

    // First frame with first-pixel latency
    new_frame();
    push_addr_frame();
    pulse_start();
    check("c1_busy", 64'(busy), 64'd1);
    check("c1_en", 64'(bram_en), 64'd1);
    check("c1_addr", 64'(read_addr), 64'd0);
    for (int g = 1; g < 4; g++) begin
      @(posedge clk); #1;
      check("read_addr", 64'(read_addr), 64'(g * 25));
      check("read_en", 64'(bram_en), 64'd1);
    end
    @(posedge clk); #1;
    check("c5_en_low", 64'(bram_en), 64'd0);
    check("c5_no_issue", 64'(enable_conv), 64'd0);
    @(posedge clk); #1;
    check("c6_issue", 64'(enable_conv), 64'd1);
    wait_done(400, 1'b0);
    @(posedge clk); #1;
    check("busy_after_done", 64'(busy), 64'd0);
    check("frame1_pulses", 64'(frame_pulses), 64'd25);
    check("frame1_done_cnt", 64'(done_cnt), 64'd1);

    // Ignored start mid-frame and in the DONE cycle
    new_frame();
    push_addr_frame();
    pulse_start();
    repeat (50) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(400, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    check("ignored_pulses", 64'(frame_pulses), 64'd25);
    check("ignored_done_cnt", 64'(done_cnt), 64'd1);
    check("ignored_idle", 64'(busy), 64'd0);
    check("ignored_queue", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset during READ of pixel 7, lane 2 (cycle c59)
    new_frame();
    push_addr_frame();
    pulse_start();
    repeat (58) @(posedge clk);
    #1;
    check("px7_lane2_addr", 64'(read_addr), 64'd57);
    check("px7_lane2_en", 64'(bram_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_en", 64'(bram_en), 64'd0);
    check("async_rst_addr", 64'(read_addr), 64'd0);
    check("async_rst_concat", conv_concat, 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_px7_pulse", 64'(frame_pulses), 64'd7);

    // Table-driven lane ordering frames (first one also checks restart from pixel 0)
    for (int v = 0; v < 3; v++) begin
      for (int a = 0; a < 100; a++) mem[a] = vecs[v].plane[a / 25];
      new_frame();
      for (int p = 0; p < 25; p++) exp_q.push_back(vecs[v].expect_concat);
      pulse_start();
      check("restart_addr", 64'(read_addr), 64'd0);
      wait_done(400, 1'b0);
      @(posedge clk); #1;
      check("vec_pulses", 64'(frame_pulses), 64'd25);
    end

    // Wrap instance: 2x3 frame at base 100, no gap
    for (int p = 0; p < 6; p++)
      exp_w_q.push_back({16'(118 + p), 16'(112 + p), 16'(106 + p), 16'(100 + p)});
    @(posedge clk); #1 start_w = 1'b1;
    @(posedge clk); #1 start_w = 1'b0;
    begin
      int  n = 0;
      bit  seen = 1'b0;
      while (!seen && n < 200) begin
        @(posedge clk); #1;
        n++;
        if (done_w) seen = 1'b1;
      end
      if (!seen) begin
        tests++;
        fails++;
        $display("FAIL w_done_timeout: got no done in 200 cycles, required done");
      end
    end
    @(posedge clk); #1;
    check("w_pulses", 64'(pulses_w), 64'd6);
    check("w_busy_low", 64'(busy_w), 64'd0);
    check("w_read_count", 64'(waddr_q.size()), 64'd24);
    if (waddr_q.size() >= 20) begin
      check("w_px4_g0", 64'(waddr_q[16]), 64'd104);
      check("w_px4_g1", 64'(waddr_q[17]), 64'd110);
      check("w_px4_g2", 64'(waddr_q[18]), 64'd116);
      check("w_px4_g3", 64'(waddr_q[19]), 64'd122);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/partial_sum_gatherer.md
# partial_sum_gatherer

Upstream feeder for the four-lane half-precision adder stage. It walks a frame of MAX_ROW×MAX_COL output pixels and reads the four 16-bit partial sums of each pixel from the partial-sum BRAM, one filter-group plane per lane. It packs them into `conv_concat` and fires a one-cycle `enable_conv` per pixel. It sits between the partial-sum BRAM read port and the adder-tree block that writes the output BRAM.

## Interface
Parameters:
- `MAX_ROW`, 5: frame rows.
- `MAX_COL`, 5: frame columns.
- `ISSUE_GAP`, 2: idle cycles inserted after each `enable_conv` pulse, because the adder stage has no backpressure.
- `BASE_ADDR`, 18'd0: address of group 0, pixel 0.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  single-cycle request to process one frame. Sampled only in IDLE.
- `Input_BRAM_en`  out  1  partial-sum BRAM read enable.
- `Input_read_addr`  out  18  partial-sum BRAM read address.
- `Input_read_data`  in  16  BRAM read data. It is valid exactly 1 cycle after the cycle in which `Input_BRAM_en` is 1.
- `conv_concat`  out  64  packed operands for the adder stage. Lane g occupies bits [16g+15:16g].
- `enable_conv`  out  1  one-cycle pulse: `conv_concat` holds a complete pixel.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE completes.
- `done`  out  1  one-cycle pulse after the last pixel of the frame is issued.

## Operation
- Memory layout: PLANE = MAX_ROW*MAX_COL, and pix = row*MAX_COL + col. The word for group g of pixel pix is at BASE_ADDR + g*PLANE + pix.
- Address generation is incremental (per-lane adds of PLANE), with no multiplier in the address path. Arithmetic is modulo 2^18, unsigned.
- Pixel order is row-major:
  - col wraps from MAX_COL-1 to 0, and row increments on that wrap.
  - The frame ends after the pixel at row MAX_ROW-1, col MAX_COL-1 is issued.
- FSM states are IDLE, READ, WAIT, ISSUE, GAP and DONE.
  - IDLE: leave when `start`=1, go to READ with pixel (0,0).
  - READ: lasts 4 cycles; lane counter g = 0..3, `Input_BRAM_en`=1, address of group g of the current pixel. → WAIT.
  - WAIT: lasts 1 cycle; `Input_BRAM_en`=0 while lane 3 data is captured. → ISSUE.
  - ISSUE: lasts 1 cycle; `enable_conv`=1. Then:
    - → GAP if ISSUE_GAP>0.
    - else → READ for the next pixel.
    - → DONE if this was the last pixel.
  - GAP: lasts ISSUE_GAP cycles; no reads. → READ for the next pixel, or → DONE if the last pixel was just issued.
  - DONE: lasts 1 cycle; `done`=1. → IDLE.
- Lane capture: `Input_read_data` is registered into lane g in the cycle after the read of group g. Lanes are overwritten in place.
- `conv_concat` is stable during ISSUE and holds its value until lane 0 of the next pixel is captured.
- `start` outside IDLE is ignored. No queuing.
- A `start` pulse in the same cycle as DONE is also ignored; it is accepted only in IDLE.
- Reset (asynchronous, at any time, including mid-frame) forces:
  - state IDLE, counters 0;
  - `Input_BRAM_en`=0, `Input_read_addr`=0, `conv_concat`=0;
  - `enable_conv`=0, `busy`=0, `done`=0.
- No partial pixel is issued after reset. After reset is released, the block waits for a new `start`.

## Timing
- Let c0 be the cycle in which `start` is sampled high in IDLE.
- `busy` is 1 from c1. Reads occur in c1–c4 (groups 0–3). WAIT is c5, and `enable_conv`=1 in c6.
- Pixel period is 6+ISSUE_GAP cycles. The next pixel's first read is in cycle c7+ISSUE_GAP.
- With k pixels, the last `enable_conv` is in c(6+(k-1)(6+ISSUE_GAP)).
- `done` falls in the cycle after the last pixel: after its GAP if ISSUE_GAP>0, or directly after ISSUE when ISSUE_GAP=0. `busy` drops in the cycle following `done`.
- `enable_conv` is never high on two consecutive cycles.
- `Input_BRAM_en` is never high in WAIT, ISSUE, GAP or DONE.

## Test plan
- **Single frame, defaults.** BRAM preloaded with word = address. Pulse `start`.
  - Expect 25 `enable_conv` pulses, spaced 8 cycles apart.
  - Pixel p carries `conv_concat` = {p+75, p+50, p+25, p} (lane 3..lane 0).
  - `done` occurs once, 1 cycle after the GAP of pixel 24.
- **First-pixel latency.** With `start` in c0, expect reads at addresses 0, 25, 50, 75 in c1–c4, `enable_conv` in c6, and `busy` high in c1.
- **Wrap / parameters.** With MAX_ROW=2, MAX_COL=3, BASE_ADDR=100, ISSUE_GAP=0:
  - Read addresses for pixel 4 are 104, 110, 116, 122.
  - Pulses are spaced 6 cycles apart, 6 pulses in total.
  - `done` occurs the cycle after the 6th ISSUE.
- **Ignored start.** Re-pulse `start` mid-frame and in the DONE cycle. Expect exactly 25 pulses and no second frame. A later `start` in IDLE runs a full second frame with identical data.
- **Reset mid-operation.** Assert `rst_n`=0 asynchronously during READ of pixel 7, lane 2.
  - All outputs go to 0 immediately, with no `enable_conv` for pixel 7.
  - After release and a new `start`, the block restarts from pixel (0,0) at address BASE_ADDR.
- **Lane ordering.** Load plane values 0x3C00, 0x4000, 0x4200, 0x4400 (1.0, 2.0, 3.0, 4.0 in fp16). Expect `conv_concat` = 64'h4400_4200_4000_3C00.
